lcrc_32_stream: RTL and testbench

- Parametrised, multi-byte-per-cycle successor to the byte-wide LCRC-32 generator.
- Consumes a TLP byte stream under valid/ready handshake.
- Generate mode: computes the 32-bit LCRC for the frame.
- Check mode: runs over the frame including its trailing LCRC and flags good/bad via the residue.
- Sits between the transmit TLP framer / replay buffer and the link, and on the receive side ahead of ACK/NAK logic.

---
 rtl/lcrc_32_stream.sv | 162 ++++++++++++++++
 tb/tb_lcrc_32_stream.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcrc_32_stream.sv
// rtl/lcrc_32_stream.sv - multi-byte-per-beat LCRC-32 generate/check engine with valid/ready stream and result handshake
// Optional LCRC_STATS_EN adds saturating good/bad check-frame counters.
module lcrc_32_stream #(
    parameter int BYTES = 4,
    parameter int LEN_W = 13,
    localparam int NB_W = $clog2(BYTES) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               mode,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [8*BYTES-1:0] s_data,
    input  logic               s_last,
    input  logic [NB_W-1:0]    s_nbytes,
    output logic               crc_valid,
    input  logic               crc_ready,
    output logic [31:0]        crc_out,
    output logic               crc_ok,
    output logic [LEN_W-1:0]   crc_len,
    output logic               len_err
`ifdef LCRC_STATS_EN
    ,
    output logic [15:0]        good_cnt,
    output logic [15:0]        bad_cnt
`endif
);

    localparam logic [31:0] POLY    = 32'hEDB88320;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
    localparam int          SW      = LEN_W + 1;
    localparam logic [SW-1:0] LEN_MAX = {1'b0, {LEN_W{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       crc_q, crc_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              err_q, err_d;
    logic              mode_q, mode_d;

    logic [NB_W-1:0]   nb_eff;
    logic [31:0]       beat_crc;
    logic [LEN_W-1:0]  base_len;
    logic [SW-1:0]     len_sum;
    logic              len_ovf;
    logic [LEN_W-1:0]  len_next;
    logic              accept;
    logic              result_acc;

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign s_ready    = reset_n && (state_q != S_DONE);
    assign accept     = s_valid && s_ready;
    assign crc_valid  = (state_q == S_DONE);
    assign result_acc = crc_valid && crc_ready;
    assign crc_out    = ~crc_q;
    assign crc_ok     = mode_q && (crc_q == RESIDUE);
    assign crc_len    = len_q;
    assign len_err    = err_q;

    // Only a last beat may be short; a zero count is promoted to one byte.
    always_comb begin
        nb_eff = NB_W'(BYTES);
        if (s_last) begin
            if (s_nbytes == '0) begin
                nb_eff = NB_W'(1);
            end else if (s_nbytes < NB_W'(BYTES)) begin
                nb_eff = s_nbytes;
            end
        end
    end

    always_comb begin
        beat_crc = (state_q == S_IDLE) ? 32'hFFFF_FFFF : crc_q;
        for (int i = 0; i < BYTES; i++) begin
            if (i < int'(nb_eff)) begin
                beat_crc = crc_byte(beat_crc, s_data[8*i +: 8]);
            end
        end
    end

    assign base_len = (state_q == S_IDLE) ? '0 : len_q;
    assign len_sum  = {1'b0, base_len} + SW'(nb_eff);
    assign len_ovf  = (len_sum > LEN_MAX);
    assign len_next = len_ovf ? {LEN_W{1'b1}} : len_sum[LEN_W-1:0];

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        len_d   = len_q;
        err_d   = err_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (accept) begin
                    crc_d   = beat_crc;
                    len_d   = len_next;
                    err_d   = ((state_q == S_IDLE) ? 1'b0 : err_q) | len_ovf;
                    if (state_q == S_IDLE) begin
                        mode_d = mode;
                    end
                    state_d = s_last ? S_DONE : S_RUN;
                end
            end
            S_DONE: begin
                if (crc_ready) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            crc_q   <= 32'hFFFF_FFFF;
            len_q   <= '0;
            err_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            len_q   <= len_d;
            err_q   <= err_d;
            mode_q  <= mode_d;
        end
    end

`ifdef LCRC_STATS_EN
    logic [15:0] good_q, bad_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            good_q <= '0;
            bad_q  <= '0;
        end else if (result_acc && mode_q) begin
            if (crc_ok) begin
                if (good_q != 16'hFFFF) good_q <= good_q + 16'd1;
            end else begin
                if (bad_q != 16'hFFFF) bad_q <= bad_q + 16'd1;
            end
        end
    end

    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;
`else
    logic unused_acc;
    assign unused_acc = result_acc;
`endif

endmodule

// File: tb/tb_lcrc_32_stream.sv
// tb/tb_lcrc_32_stream.sv - table-driven scoreboard bench for lcrc_32_stream (BYTES=4/LEN_W=4 and BYTES=1)
module tb_lcrc_32_stream;

    localparam int BYTES = 4;
    localparam int LEN_W = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        mode, s_valid, s_ready, s_last;
    logic [31:0] s_data;
    logic [2:0]  s_nbytes;
    logic        crc_valid, crc_ready, crc_ok, len_err;
    logic [31:0] crc_out;
    logic [3:0]  crc_len;

    logic        b1_mode, b1_valid, b1_ready, b1_last, b1_nbytes;
    logic [7:0]  b1_data;
    logic        b1_crc_valid, b1_crc_ready, b1_crc_ok, b1_len_err;
    logic [31:0] b1_crc_out;
    logic [12:0] b1_crc_len;
`ifdef LCRC_STATS_EN
    logic [15:0] good_cnt, bad_cnt, b1_good_cnt, b1_bad_cnt;
`endif

    lcrc_32_stream #(.BYTES(BYTES), .LEN_W(LEN_W)) u_dut (
        .clk(clk), .reset_n(rst_n), .mode(mode), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .s_nbytes(s_nbytes),
        .crc_valid(crc_valid), .crc_ready(crc_ready), .crc_out(crc_out), .crc_ok(crc_ok),
        .crc_len(crc_len), .len_err(len_err)
`ifdef LCRC_STATS_EN
        , .good_cnt(good_cnt), .bad_cnt(bad_cnt)
`endif
    );

    lcrc_32_stream #(.BYTES(1)) u_dut1 (
        .clk(clk), .reset_n(rst_n), .mode(b1_mode), .s_valid(b1_valid), .s_ready(b1_ready),
        .s_data(b1_data), .s_last(b1_last), .s_nbytes(b1_nbytes),
        .crc_valid(b1_crc_valid), .crc_ready(b1_crc_ready), .crc_out(b1_crc_out), .crc_ok(b1_crc_ok),
        .crc_len(b1_crc_len), .len_err(b1_len_err)
`ifdef LCRC_STATS_EN
        , .good_cnt(b1_good_cnt), .bad_cnt(b1_bad_cnt)
`endif
    );

    typedef struct {
        logic         mode;
        int           len;
        logic [191:0] data;
        bit           gap;
        bit           zero_nb;
        logic [31:0]  exp_crc;
        logic         exp_ok;
        logic [3:0]   exp_len;
        logic         exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] crc;
        logic        ok;
        logic [3:0]  len;
        logic        err;
        logic        mode;
    } exp_t;

    localparam int NVEC = 9;
    vec_t vt [NVEC];
    exp_t sb [$];

    int n_vec = 0;
    int n_err = 0;
    int n_res = 0;
    int exp_good = 0;
    int exp_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_crc(input logic [191:0] d, input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[8*i + b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && crc_valid === 1'b1 && crc_ready === 1'b1) begin
            n_res++;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got crc 0x%08h expected no result", crc_out);
            end else begin
                e = sb.pop_front();
                check("crc_out", crc_out, e.crc);
                check("crc_ok", crc_ok, e.ok);
                check("crc_len", crc_len, e.len);
                check("len_err", len_err, e.err);
                if (e.mode) begin
                    if (e.ok) exp_good++;
                    else      exp_bad++;
                end
            end
        end
    end

    task automatic send_frame(input int k);
        vec_t        v;
        int          nbeats;
        int          t;
        logic [31:0] w;
        v = vt[k];
        nbeats = (v.len + 3) / 4;
        sb.push_back('{crc: v.exp_crc, ok: v.exp_ok, len: v.exp_len, err: v.exp_err, mode: v.mode});
        for (int b = 0; b < nbeats; b++) begin
            if (b > 0 && v.gap) begin
                @(negedge clk);
                s_valid = 1'b0;
                s_data  = $urandom;
            end
            @(negedge clk);
            w = $urandom;
            for (int j = 0; j < 4; j++) begin
                if (4*b + j < v.len) w[8*j +: 8] = v.data[8*(4*b + j) +: 8];
            end
            s_data  = w;
            s_valid = 1'b1;
            s_last  = (b == nbeats - 1);
            if (s_last) s_nbytes = (v.zero_nb && (v.len - 4*b == 1)) ? 3'd0 : 3'(v.len - 4*b);
            else        s_nbytes = 3'($urandom_range(0, 7));
            mode    = (b == 0) ? v.mode : ~v.mode;
            t = 0;
            while (!s_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) begin
                n_vec++;
                n_err++;
                $display("FAIL beat_timeout: vector %0d got s_ready=0 expected 1", k);
            end
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("latency_valid", crc_valid, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [191:0] d, d2;
        logic [31:0]  m;
        int           base_res;
        int           t;

        d = '0;
        for (int i = 0; i < 9; i++) d[8*i +: 8] = 8'(49 + i);
        vt[0] = '{mode: 1'b0, len: 9, data: d, gap: 1'b0, zero_nb: 1'b0,
                  exp_crc: 32'hCBF43926, exp_ok: 1'b0, exp_len: 4'd9, exp_err: 1'b0};
        d[72 +: 32] = 32'hCBF43926;
        vt[1] = '{mode: 1'b1, len: 13, data: d, gap: 1'b1, zero_nb: 1'b0,
                  exp_crc: 32'h2144DF1C, exp_ok: 1'b1, exp_len: 4'd13, exp_err: 1'b0};
        d2 = d;
        d2[0] = ~d2[0];
        m = model_crc(d2, 13);
        vt[2] = '{mode: 1'b1, len: 13, data: d2, gap: 1'b0, zero_nb: 1'b0,
                  exp_crc: m, exp_ok: (m == 32'h2144DF1C), exp_len: 4'd13, exp_err: 1'b0};
        d = '0;
        vt[3] = '{mode: 1'b0, len: 1, data: d, gap: 1'b0, zero_nb: 1'b1,
                  exp_crc: 32'hD202EF8D, exp_ok: 1'b0, exp_len: 4'd1, exp_err: 1'b0};
        d[31:0] = 32'h64636261;
        vt[4] = '{mode: 1'b0, len: 4, data: d, gap: 1'b0, zero_nb: 1'b0,
                  exp_crc: model_crc(d, 4), exp_ok: 1'b0, exp_len: 4'd4, exp_err: 1'b0};
        d[63:32] = model_crc(d, 4);
        vt[6] = '{mode: 1'b1, len: 8, data: d, gap: 1'b1, zero_nb: 1'b0,
                  exp_crc: 32'h2144DF1C, exp_ok: 1'b1, exp_len: 4'd8, exp_err: 1'b0};
        d = '0;
        for (int i = 0; i < 20; i++) d[8*i +: 8] = 8'(i*7 + 3);
        m = model_crc(d, 20);
        vt[5] = '{mode: 1'b1, len: 20, data: d, gap: 1'b1, zero_nb: 1'b0,
                  exp_crc: m, exp_ok: (m == 32'h2144DF1C), exp_len: 4'd15, exp_err: 1'b1};
        d = '0;
        for (int i = 0; i < 15; i++) d[8*i +: 8] = 8'(255 - i);
        vt[7] = '{mode: 1'b0, len: 15, data: d, gap: 1'b0, zero_nb: 1'b0,
                  exp_crc: model_crc(d, 15), exp_ok: 1'b0, exp_len: 4'd15, exp_err: 1'b0};
        d = '0;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(i*i);
        vt[8] = '{mode: 1'b0, len: 16, data: d, gap: 1'b0, zero_nb: 1'b0,
                  exp_crc: model_crc(d, 16), exp_ok: 1'b0, exp_len: 4'd15, exp_err: 1'b1};

        rst_n = 1'b0;
        mode = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_nbytes = '0;
        crc_ready = 1'b1;
        b1_mode = 1'b0; b1_valid = 1'b0; b1_last = 1'b0; b1_data = '0; b1_nbytes = 1'b1;
        b1_crc_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_crc_valid", crc_valid, 1'b0);
        check("rst_crc_out", crc_out, 32'h0);
        check("rst_crc_ok", crc_ok, 1'b0);
        check("rst_crc_len", crc_len, 4'd0);
        check("rst_len_err", len_err, 1'b0);
        rst_n = 1'b1;
        #1;
        check("post_rst_s_ready", s_ready, 1'b1);

        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            b1_data  = 8'(49 + i);
            b1_valid = 1'b1;
            b1_last  = (i == 8);
            t = 0;
            while (!b1_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            @(posedge clk);
        end
        @(negedge clk);
        b1_valid = 1'b0;
        b1_last  = 1'b0;
        check("b1_crc_valid", b1_crc_valid, 1'b1);
        check("b1_crc_out", b1_crc_out, 32'hCBF43926);
        check("b1_crc_len", b1_crc_len, 13'd9);
        check("b1_crc_ok", b1_crc_ok, 1'b0);

        for (int k = 0; k < NVEC; k++) send_frame(k);

        @(posedge clk);
        #1 crc_ready = 1'b0;
        send_frame(0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_crc_valid", crc_valid, 1'b1);
            check("bp_crc_out", crc_out, 32'hCBF43926);
            check("bp_s_ready", s_ready, 1'b0);
        end
        @(posedge clk);
        #1 crc_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_next_s_ready", s_ready, 1'b1);
        check("bp_next_crc_valid", crc_valid, 1'b0);

        base_res = n_res;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            s_data = $urandom; s_valid = 1'b1; s_last = 1'b0; s_nbytes = 3'd4; mode = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("midrst_s_ready", s_ready, 1'b0);
        check("midrst_crc_len", crc_len, 4'd0);
        check("midrst_crc_out", crc_out, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(0);
        repeat (5) @(negedge clk);
        check("midrst_result_count", 32'(n_res - base_res), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);
`ifdef LCRC_STATS_EN
        check("good_cnt", good_cnt, 16'(exp_good));
        check("bad_cnt", bad_cnt, 16'(exp_bad));
        check("b1_good_cnt", b1_good_cnt, 16'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
